// File: rtl/car_request_pkg.sv
// ---------------------------------------------------------------------------
// car_request_pkg
// Shared traffic-controller package. It holds the state encoding used by the
// car request FSM (and by the timer / state machine blocks that consume the
// car request), the default debounce length and the pending counter limit.
//
// Contents:
//   car_state_t        FSM state enum: IDLE=0, ARMED=1, SERVING=2
//   DEB_TICKS_DEFAULT  default number of stable tick_1ms strobes to accept a
//                      sensor level change
//   DEB_CNT_W          width of the debounce tick counter
//   PENDING_W          width of the pending arrival counter
//   PENDING_MAX        saturation value of the pending arrival counter
//   pending_next()     next value of the pending arrival counter
// ---------------------------------------------------------------------------
package car_request_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    SERVING = 2'd2
  } car_state_t;

  localparam int DEB_TICKS_DEFAULT = 20;
  localparam int DEB_CNT_W         = 8;
  localparam int PENDING_W         = 4;

  localparam logic [PENDING_W-1:0] PENDING_MAX = 4'd15;

  // A serve empties the queue of arrivals; an arrival landing in the very
  // same cycle is not lost, so it becomes the first entry of the new queue.
  // Arrivals otherwise accumulate and stick at PENDING_MAX.
  function automatic logic [PENDING_W-1:0] pending_next(
    input logic [PENDING_W-1:0] cur,
    input logic                 serve,
    input logic                 arrival
  );
    logic [PENDING_W-1:0] nxt;
    nxt = cur;
    if (serve) begin
      nxt = arrival ? 4'd1 : 4'd0;
    end else if (arrival && (cur != PENDING_MAX)) begin
      nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/car_request_sync_debounce.sv
// ---------------------------------------------------------------------------
// car_request_sync_debounce  (the sync_debounce block of car_request)
// Brings the asynchronous, bouncy side-road sensor into the clock domain
// through a two-flop synchronizer, then accepts a level change only after
// the synchronized level has differed from the accepted level for DEB_TICKS
// consecutive tick_1ms strobes.
//
// Parameters:
//   DEB_TICKS   stable ticks needed to accept a change, legal range 2..255
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   sensor_raw  raw car detector, asynchronous, high = car present
//   tick_1ms    single-cycle enable strobe pacing the debounce counter
//   debounced   registered, debounced sensor level
// ---------------------------------------------------------------------------
module car_request_sync_debounce
  import car_request_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_raw,
  input  logic tick_1ms,
  output logic debounced
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_TICKS - 1);

  logic                 s_meta;
  logic                 s_sync;
  logic [DEB_CNT_W-1:0] deb_cnt;

  // Two-flop synchronizer: s_meta may go metastable, s_sync is the first
  // point where the sensor may be used by any logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
    end else begin
      s_meta <= sensor_raw;
      s_sync <= s_meta;
    end
  end

  // Debounce counter and accepted level. Any cycle in which the synchronized
  // level agrees with the accepted level restarts the count, so only an
  // unbroken run of DEB_TICKS ticks of disagreement flips the level. The
  // flip happens on the tick that completes the run, which also restarts
  // the count for the next change.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt   <= '0;
      debounced <= 1'b0;
    end else if (s_sync == debounced) begin
      deb_cnt <= '0;
    end else if (tick_1ms) begin
      if (deb_cnt == DEB_LAST) begin
        debounced <= ~debounced;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/car_request.sv
// ---------------------------------------------------------------------------
// car_request
// Side-road car request logic for the traffic controller. The debounced
// sensor level is edge-detected to count arrivals; a small FSM latches a
// request (car) that the timer and state machine consume, drops it when
// the side-road green phase starts (serve), and refuses to re-request
// until the car that was served has left the sensor.
//
// Parameters:
//   DEB_TICKS    stable tick_1ms strobes to accept a sensor change (2..255)
// Ports:
//   clk          system clock (divided clock of the timer / state machine)
//   rst          synchronous active-high reset, one clock
//   sensor_raw   raw side-road car detector, asynchronous and bouncy
//   tick_1ms     single-cycle enable strobe pacing debouncing
//   serve        single-cycle pulse at the start of the side-road green
//   car          registered, latched car request
//   car_pulse    one-cycle strobe on each accepted arrival
//   debounced    registered, debounced sensor level
//   pending_cnt  arrivals since the last serve, saturating at 15
// ---------------------------------------------------------------------------
module car_request
  import car_request_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sensor_raw,
  input  logic                 tick_1ms,
  input  logic                 serve,
  output logic                 car,
  output logic                 car_pulse,
  output logic                 debounced,
  output logic [PENDING_W-1:0] pending_cnt
);

  car_state_t state;
  logic       debounced_d;

  car_request_sync_debounce #(
    .DEB_TICKS (DEB_TICKS)
  ) u_sync_debounce (
    .clk        (clk),
    .rst        (rst),
    .sensor_raw (sensor_raw),
    .tick_1ms   (tick_1ms),
    .debounced  (debounced)
  );

  // One-cycle delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      debounced_d <= 1'b0;
    end else begin
      debounced_d <= debounced;
    end
  end

  // Both inputs of the edge detect are registers, so car_pulse is glitch
  // free and lasts exactly one cycle per accepted arrival.
  assign car_pulse = debounced & ~debounced_d;

  // Request FSM with car registered alongside the state so that car is high
  // exactly while the FSM sits in ARMED. An arrival in the same cycle as a
  // serve is a new car, so ARMED is kept rather than losing it. SERVING
  // waits for the served car to leave before a new arrival may arm again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      car   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (car_pulse) begin
            state <= ARMED;
            car   <= 1'b1;
          end
        end
        ARMED: begin
          if (serve && !car_pulse) begin
            state <= SERVING;
            car   <= 1'b0;
          end
        end
        SERVING: begin
          if (!debounced) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          car   <= 1'b0;
        end
      endcase
    end
  end

  // Pending arrival counter: counts accepted arrivals since the last serve.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_cnt <= '0;
    end else begin
      pending_cnt <= pending_next(pending_cnt, serve, car_pulse);
    end
  end

endmodule

// File: tb/tb_car_request.sv
// ---------------------------------------------------------------------------
// tb_car_request
// Self-checking bench for car_request with DEB_TICKS=4 and tick_1ms every
// 5 cycles: a table of segment vectors, hand-written multi-cycle sequences
// (exact debounce latency, saturation with coincident serve) and a random
// phase compared each cycle against a behavioural request model.
// ---------------------------------------------------------------------------
module tb_car_request;

  localparam int DEB  = 4;
  localparam int TPER = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sensor_raw = 1'b0;
  logic       tick_1ms = 1'b0;
  logic       serve = 1'b0;
  logic       car;
  logic       car_pulse;
  logic       debounced;
  logic [3:0] pending_cnt;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // Behavioural model state: raw sensor history (two-cycle delay), accepted
  // level and its previous value, stable-tick run length, request flags.
  bit m_hist1, m_hist2;
  bit m_lvl, m_lvl_prev;
  int m_run;
  bit m_req;
  bit m_wait_leave;
  int m_pend;

  typedef struct {
    bit       raw;
    bit       srv;
    bit       rs;
    int       cycles;
    bit       e_car;
    bit       e_deb;
    bit       e_pulse;
    int       e_pend;
  } vec_t;

  vec_t vecs[$];

  car_request #(.DEB_TICKS(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_raw  (sensor_raw),
    .tick_1ms    (tick_1ms),
    .serve       (serve),
    .car         (car),
    .car_pulse   (car_pulse),
    .debounced   (debounced),
    .pending_cnt (pending_cnt)
  );

  always #5 clk = ~clk;

  // Request model, one clock edge per call, from the behavioural rules:
  // an arrival is a rise of the accepted level; a request is held from an
  // arrival until a serve that does not coincide with a new arrival; after
  // such a serve no request is taken until the car has left.
  task automatic modelStep(input bit raw, input bit tk, input bit srv, input bit rs);
    bit arrival;
    bit lvl_before;
    arrival    = m_lvl && !m_lvl_prev;
    lvl_before = m_lvl;
    if (rs) begin
      m_hist1 = 0; m_hist2 = 0; m_lvl = 0; m_lvl_prev = 0;
      m_run = 0; m_req = 0; m_wait_leave = 0; m_pend = 0;
    end else begin
      if (m_hist2 == m_lvl) m_run = 0;
      else if (tk) begin
        m_run = m_run + 1;
        if (m_run == DEB) begin
          m_lvl = !m_lvl;
          m_run = 0;
        end
      end
      m_hist2    = m_hist1;
      m_hist1    = raw;
      m_lvl_prev = lvl_before;
      if (m_req) begin
        if (srv && !arrival) begin
          m_req = 0;
          m_wait_leave = 1;
        end
      end else if (m_wait_leave) begin
        if (!lvl_before) m_wait_leave = 0;
      end else if (arrival) begin
        m_req = 1;
      end
      if (srv) m_pend = arrival ? 1 : 0;
      else if (arrival) m_pend = (m_pend >= 15) ? 15 : m_pend + 1;
    end
  endtask

  task automatic applyStimulus(input bit raw, input bit srv, input bit rs);
    bit tk;
    @(negedge clk);
    tk         = ((cyc % TPER) == 0);
    sensor_raw = raw;
    serve      = srv;
    rst        = rs;
    tick_1ms   = tk;
    @(posedge clk);
    modelStep(raw, tk, srv, rs);
    cyc = cyc + 1;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " car"},       32'(car),         32'(m_req));
    checkOutput({tag, " debounced"}, 32'(debounced),   32'(m_lvl));
    checkOutput({tag, " car_pulse"}, 32'(car_pulse),   32'(m_lvl && !m_lvl_prev));
    checkOutput({tag, " pending"},   32'(pending_cnt), 32'(m_pend));
  endtask

  task automatic addVec(input bit raw, input bit srv, input bit rs, input int n,
                        input bit ec, input bit ed, input bit ep, input int epd);
    vec_t v;
    v.raw = raw; v.srv = srv; v.rs = rs; v.cycles = n;
    v.e_car = ec; v.e_deb = ed; v.e_pulse = ep; v.e_pend = epd;
    vecs.push_back(v);
  endtask

  // Holds the sensor high until an arrival strobe is seen (bounded).
  task automatic waitArrival(input string tag);
    bit found;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (car_pulse === 1'b1) begin
        found = 1;
        break;
      end
    end
    checkOutput({tag, " arrival_seen"}, 32'(found), 32'd1);
  endtask

  // Holds the sensor low until the debounced level drops (bounded).
  task automatic waitLeave(input string tag);
    bit found;
    found = 0;
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (debounced === 1'b0) begin
        found = 1;
        break;
      end
    end
    checkOutput({tag, " leave_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    int k, t0, edge_e;
    bit raw;
    int hold;

    // raw, serve, rst, cycles, exp car, debounced, car_pulse, pending
    addVec(0, 0, 1,  2, 0, 0, 0, 0);  // reset state
    addVec(1, 0, 0, 12, 0, 0, 0, 0);  // bounce of at most 3 ticks
    addVec(0, 0, 0, 10, 0, 0, 0, 0);
    addVec(1, 0, 0, 30, 1, 1, 0, 1);  // steady car -> request
    addVec(1, 1, 0,  1, 0, 1, 0, 0);  // serve while still parked
    addVec(1, 0, 0, 30, 0, 1, 0, 0);  // no re-request while parked
    addVec(0, 0, 0, 30, 0, 0, 0, 0);  // car leaves -> idle
    addVec(1, 0, 0, 30, 1, 1, 0, 1);
    addVec(0, 0, 0, 30, 1, 0, 0, 1);  // leaving does not drop request
    addVec(1, 0, 0, 30, 1, 1, 0, 2);
    addVec(0, 0, 0, 30, 1, 0, 0, 2);
    addVec(1, 0, 0, 30, 1, 1, 0, 3);
    addVec(1, 0, 1,  1, 0, 0, 0, 0);  // reset while armed, pending=3
    addVec(1, 0, 0, 30, 1, 1, 0, 1);  // re-detected after full debounce
    addVec(1, 1, 0,  1, 0, 1, 0, 0);
    addVec(0, 0, 0, 30, 0, 0, 0, 0);
    addVec(0, 1, 0,  1, 0, 0, 0, 0);  // serve in idle ignored

    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].cycles; c++) begin
        applyStimulus(vecs[i].raw, (c == 0) ? vecs[i].srv : 1'b0, (c == 0) ? vecs[i].rs : 1'b0);
      end
      checkOutput($sformatf("row%0d car", i),       32'(car),         32'(vecs[i].e_car));
      checkOutput($sformatf("row%0d debounced", i), 32'(debounced),   32'(vecs[i].e_deb));
      checkOutput($sformatf("row%0d car_pulse", i), 32'(car_pulse),   32'(vecs[i].e_pulse));
      checkOutput($sformatf("row%0d pending", i),   32'(pending_cnt), 32'(vecs[i].e_pend));
    end

    // Exact latency: two sync edges, then the 4th tick edge flips the level.
    k      = cyc;
    t0     = ((k + 2 + TPER - 1) / TPER) * TPER;
    edge_e = t0 + (DEB - 1) * TPER;
    for (int e = k; e <= edge_e + 1; e++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("lat e%0d debounced", e - k), 32'(debounced), 32'(e >= edge_e));
      checkOutput($sformatf("lat e%0d car_pulse", e - k), 32'(car_pulse), 32'(e == edge_e));
      checkOutput($sformatf("lat e%0d car", e - k),       32'(car),       32'(e >= edge_e + 1));
    end
    checkOutput("lat pending", 32'(pending_cnt), 32'd1);

    // Saturation: 17 arrivals without serve, then serve with an arrival.
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int a = 1; a <= 17; a++) begin
      waitArrival($sformatf("sat%0d", a));
      waitLeave($sformatf("sat%0d", a));
      checkOutput($sformatf("sat%0d pending", a), 32'(pending_cnt), 32'((a > 15) ? 15 : a));
      checkOutput($sformatf("sat%0d car", a),     32'(car),         32'd1);
    end
    waitArrival("coinc");
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("coinc pending",   32'(pending_cnt), 32'd1);
    checkOutput("coinc car",       32'(car),         32'd1);
    checkOutput("coinc car_pulse", 32'(car_pulse),   32'd0);

    // Random phase against the model.
    raw  = 0;
    hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold == 0) begin
        raw  = bit'($urandom_range(0, 1));
        hold = $urandom_range(1, 35);
      end
      hold = hold - 1;
      applyStimulus(raw, ($urandom_range(0, 24) == 0), ($urandom_range(0, 399) == 0));
      checkModel("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/car_request.md
CAR_REQUEST -- requirements
Module: car_request

Interface
REQ-001 Parameter DEB_TICKS, default 20, SHALL set the number of consecutive tick_1ms strobes of stable input needed to accept a sensor level change; legal range 2..255.
REQ-002 clk  input  1  system clock, the divided clock that drives the timer and state machine.
REQ-003 rst  input  1  reset: one clock, synchronous, active-high.
REQ-004 sensor_raw  input  1  raw side-road car detector or switch, asynchronous and bouncy, high = car present.
REQ-005 tick_1ms  input  1  single-cycle enable strobe that paces debouncing.
REQ-006 serve  input  1  single-cycle pulse from the state machine when the side-road green phase starts.
REQ-007 car  output  1  registered, debounced, latched car request to the timer and state machine.
REQ-008 car_pulse  output  1  one-cycle strobe on each accepted arrival, meaning a debounced rising edge.
REQ-009 debounced  output  1  registered, debounced sensor level.
REQ-010 pending_cnt  output  4  arrivals since the last serve, saturating.

Function
REQ-011 sensor_raw SHALL pass through a 2-flop synchronizer before any other use; its output is s_sync.
REQ-012 The debounce counter SHALL be 8 bits wide and SHALL clear on any cycle where s_sync equals debounced.
REQ-013 The counter SHALL increment on each tick_1ms while s_sync differs from debounced.
REQ-014 On the tick where the counter equals DEB_TICKS-1, debounced SHALL toggle on the next edge and the counter SHALL clear.
REQ-015 Sensor-to-debounced latency SHALL be 2 sync cycles plus DEB_TICKS ticks; a glitch shorter than DEB_TICKS ticks SHALL produce no change.
REQ-016 car_pulse SHALL equal debounced AND NOT debounced_d, where debounced_d is debounced delayed by one cycle; it is high for exactly one cycle per rising edge.
REQ-017 The FSM states SHALL be IDLE, ARMED and SERVING; car SHALL be 1 only in ARMED.
REQ-018 IDLE SHALL go to ARMED on car_pulse; serve in IDLE SHALL be ignored.
REQ-019 ARMED SHALL go to SERVING on serve without car_pulse; on serve and car_pulse in the same cycle it SHALL stay ARMED.
REQ-020 SERVING SHALL go to IDLE when debounced is 0; otherwise it SHALL hold, so a car still parked after service does not re-request.
REQ-021 car SHALL rise the cycle after car_pulse and fall the cycle after serve.
REQ-022 pending_cnt SHALL increment on car_pulse, saturating at 15.
REQ-023 pending_cnt SHALL clear to 0 on serve; on serve and car_pulse in the same cycle it SHALL load 1.
REQ-024 A tick_1ms coincident with serve or car_pulse SHALL be processed normally, with no lost or double counts.

Reset
REQ-025 On rst, all outputs SHALL be 0: car, car_pulse, debounced and pending_cnt.
REQ-026 On rst, the FSM SHALL go to IDLE, the debounce counter, both sync flops and debounced_d SHALL clear, and rst SHALL take priority over all inputs.
REQ-027 Reset asserted mid-debounce or in ARMED SHALL drop the pending request; the car, if still present, SHALL be re-detected after a full debounce from s_sync = 1.

Structure
REQ-028 The FSM state enum (IDLE=2'd0, ARMED=2'd1, SERVING=2'd2) and the DEB_TICKS default SHALL live in the shared traffic package used by the timer and state machine.
REQ-029 Synchronizer, debounce counter and debounced register SHALL form one sub-module, sync_debounce; the edge detect, FSM and counter SHALL stay in car_request.
REQ-030 car SHALL connect directly to the car input of the timer and state machine blocks; the top-level car port SHALL move to sensor_raw.

Verification (DEB_TICKS=4, tick_1ms every 5 cycles)
REQ-031 Scenario 1 -- hold sensor_raw=1 steady: debounced rises after the 4th tick following sync, car_pulse is high for 1 cycle, car=1 on the next cycle, pending_cnt=1.
REQ-032 Scenario 2 -- bounce of 3 ticks high then low: debounced, car and pending_cnt stay 0.
REQ-033 Scenario 3 -- car ARMED, pulse serve with sensor still 1: car=0 next cycle, state SERVING, pending_cnt=0; no new car until sensor is low for 4 ticks and then high for 4 ticks.
REQ-034 Scenario 4 -- 17 debounced arrivals with no serve: pending_cnt saturates at 15; then serve coincident with car_pulse gives pending_cnt=1 and car stays 1.
REQ-035 Scenario 5 -- rst for 1 cycle while ARMED with pending_cnt=3 and sensor_raw=1: all outputs 0 next cycle, car=1 again only after 2+4 ticks' debounce.
REQ-036 Scenario 6 -- serve in IDLE: no state or output change.
